// File: rtl/imem_load_arb.sv
// Two-requester arbiter that streams a program into instruction memory, waits for the
// memory to replay it, and reports completion with an error flag.
module imem_load_arb #(
  parameter int INST_WIDTH    = 32,
  parameter int IM_ADDR_WIDTH = 5,
  parameter int TMO           = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [IM_ADDR_WIDTH:0] len0,
  input  logic [IM_ADDR_WIDTH:0] len1,
  input  logic                   valid0,
  input  logic                   valid1,
  input  logic [INST_WIDTH-1:0]  data0,
  input  logic [INST_WIDTH-1:0]  data1,
  output logic                   ready0,
  output logic                   ready1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   done0,
  output logic                   done1,
  output logic                   err0,
  output logic                   err1,
  output logic                   inst_v,
  output logic [INST_WIDTH-1:0]  inst_in,
  input  logic                   inst_out_v,
  output logic                   busy
);

  localparam int CW = IM_ADDR_WIDTH + 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [CW-1:0] MaxLen = {1'b1, {IM_ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RPL, REPLAY, DONE} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0] inst_in_q, inst_in_d;

  logic                  grantSel;
  logic [CW-1:0]         grantLen;
  logic                  lenBad;
  logic                  ownValid;
  logic [INST_WIDTH-1:0] ownData;
  logic [CW-1:0]         wcntInc;
  logic [CW-1:0]         rcntInc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      inst_v_q  <= 1'b0;
      inst_in_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      inst_v_q  <= inst_v_d;
      inst_in_q <= inst_in_d;
    end
  end

  // On a tie the pointer picks; otherwise whichever requester is asking wins.
  assign grantSel = req1 && (!req0 || ptr_q);
  assign grantLen = grantSel ? len1 : len0;
  assign lenBad   = (grantLen == '0) || (grantLen > MaxLen);
  assign ownValid = owner_q ? valid1 : valid0;
  assign ownData  = owner_q ? data1 : data0;
  assign wcntInc  = (wcnt_q == '1) ? wcnt_q : wcnt_q + CW'(1);
  assign rcntInc  = (rcnt_q == '1) ? rcnt_q : rcnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    tcnt_d    = tcnt_q;
    inst_v_d  = 1'b0;
    inst_in_d = inst_in_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = grantSel;
          len_d   = grantLen;
          wcnt_d  = '0;
          rcnt_d  = '0;
          tcnt_d  = '0;
          err_d   = lenBad;
          state_d = lenBad ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (ownValid && (wcnt_q < len_q)) begin
          inst_v_d  = 1'b1;
          inst_in_d = ownData;
          wcnt_d    = wcntInc;
          if (wcntInc >= len_q) state_d = WAIT_RPL;
        end else if (wcnt_q != '0) begin
          // The memory sizes its replay from the inst_v run, so a gap ends the burst.
          err_d   = 1'b1;
          state_d = WAIT_RPL;
        end
      end
      WAIT_RPL: begin
        if (inst_out_v) begin
          rcnt_d  = rcntInc;
          state_d = REPLAY;
        end else if (tcnt_q == TW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      REPLAY: begin
        if (inst_out_v) begin
          rcnt_d = rcntInc;
        end else begin
          if (rcnt_q != wcnt_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    gnt0    = busy && !owner_q;
    gnt1    = busy && owner_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    err0    = 1'b0;
    err1    = 1'b0;
    inst_v  = inst_v_q;
    inst_in = inst_in_q;
    if ((state_q == LOAD) && (wcnt_q < len_q)) begin
      ready0 = !owner_q;
      ready1 = owner_q;
    end
    if (state_q == DONE) begin
      done0 = !owner_q;
      done1 = owner_q;
      err0  = !owner_q && err_q;
      err1  = owner_q && err_q;
    end
  end

endmodule
